// File: rtl/bayer_mosaic_gen_if.sv
// rtl/bayer_mosaic_gen_if.sv - RGB pixel in / Bayer raw out bundle for bayer_mosaic_gen
//
// Purpose: groups the RGB input stream and the Bayer raw output stream of
// bayer_mosaic_gen so source, converter and consumers share one bundle.
// Signals:
//   iFVAL            frame valid (rising edge starts a frame)
//   iDVAL            pixel valid inside a line
//   iRed/iGreen/iBlue 12-bit RGB components
//   oDATA            12-bit Bayer raw sample
//   oDVAL            oDATA valid, one cycle per accepted pixel
//   oX_Cont/oY_Cont  11-bit column/row of the sample on oDATA
//   oERR             sticky malformed-frame flag
// Modports: master = RGB source side, slave = converter side.
interface bayer_mosaic_gen_if;
  logic        iFVAL;
  logic        iDVAL;
  logic [11:0] iRed;
  logic [11:0] iGreen;
  logic [11:0] iBlue;
  logic [11:0] oDATA;
  logic        oDVAL;
  logic [10:0] oX_Cont;
  logic [10:0] oY_Cont;
  logic        oERR;

  modport master (
    output iFVAL, iDVAL, iRed, iGreen, iBlue,
    input  oDATA, oDVAL, oX_Cont, oY_Cont, oERR
  );

  modport slave (
    input  iFVAL, iDVAL, iRed, iGreen, iBlue,
    output oDATA, oDVAL, oX_Cont, oY_Cont, oERR
  );
endinterface

// File: rtl/bayer_mosaic_gen.sv
// rtl/bayer_mosaic_gen.sv - RGB stream to 12-bit Bayer raw stream with coordinates
//
// Purpose: tracks column/row from the valid strobes, picks one colour
// component per pixel by the fixed Bayer phase {row[0], col[0]}
// (00 G1, 01 R, 10 B, 11 G2) and flags malformed frames.
// Ports:
//   iCLK  pixel clock, rising edge
//   iRST  asynchronous active-low reset
//   bus   bayer_mosaic_gen_if.slave (RGB in, Bayer raw + coordinates + error out)
// Parameters: H_ACTIVE pixels per line, V_ACTIVE lines per frame.
module bayer_mosaic_gen #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic              iCLK,
  input  logic              iRST,
  bayer_mosaic_gen_if.slave bus
);

  localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM = 11'(V_ACTIVE);

  // Edge-detect copies of the strobes.
  logic        fval_q;
  logic        dval_q;
  // Set once iFVAL has been seen low after reset, so an iFVAL already high
  // when reset releases is not mistaken for a frame start.
  logic        armed_q, armed_d;
  // Inside a frame that started with a genuine iFVAL rise.
  logic        in_frame_q, in_frame_d;

  logic [10:0] col_q, col_d;
  logic [10:0] row_q, row_d;
  logic [11:0] data_q, data_d;
  logic        dval_o_q, dval_o_d;
  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic        err_q, err_d;

  logic        frame_rise;
  logic        fv;
  logic        eol;
  logic [10:0] col_eff;
  logic [10:0] row_eff;

  always_comb begin
    frame_rise = bus.iFVAL & ~fval_q & armed_q;
    fv         = bus.iFVAL & (in_frame_q | frame_rise);
    // A line ends when iDVAL drops or the frame drops under a running line.
    eol        = dval_q & in_frame_q & (~bus.iDVAL | ~fv);
    // Frame start applies to the pixel sampled in the same cycle.
    col_eff    = frame_rise ? 11'd0 : col_q;
    row_eff    = frame_rise ? 11'd0 : row_q;
    armed_d    = armed_q | ~bus.iFVAL;
    in_frame_d = fv;
  end

  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    err_d    = err_q;
    data_d   = data_q;
    x_d      = x_q;
    y_d      = y_q;
    dval_o_d = 1'b0;

    if (frame_rise) begin
      col_d = 11'd0;
      row_d = 11'd0;
      err_d = 1'b0;
    end

    if (bus.iDVAL) begin
      if (!fv) begin
        err_d = 1'b1;
      end else if ((col_eff < H_LIM) && (row_eff < V_LIM)) begin
        dval_o_d = 1'b1;
        x_d      = col_eff;
        y_d      = row_eff;
        col_d    = col_eff + 11'd1;
        case ({row_eff[0], col_eff[0]})
          2'b01:   data_d = bus.iRed;
          2'b10:   data_d = bus.iBlue;
          default: data_d = bus.iGreen;
        endcase
      end else begin
        // Overrun: dropped, counters stay pinned at their limits.
        err_d = 1'b1;
      end
    end

    // eol never coincides with an accepted pixel or a frame rise.
    if (eol) begin
      col_d = 11'd0;
      row_d = (row_q >= V_LIM) ? V_LIM : row_q + 11'd1;
      if (col_q != H_LIM) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      fval_q     <= 1'b0;
      dval_q     <= 1'b0;
      armed_q    <= 1'b0;
      in_frame_q <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      data_q     <= '0;
      dval_o_q   <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      err_q      <= 1'b0;
    end else begin
      fval_q     <= bus.iFVAL;
      dval_q     <= bus.iDVAL;
      armed_q    <= armed_d;
      in_frame_q <= in_frame_d;
      col_q      <= col_d;
      row_q      <= row_d;
      data_q     <= data_d;
      dval_o_q   <= dval_o_d;
      x_q        <= x_d;
      y_q        <= y_d;
      err_q      <= err_d;
    end
  end

  assign bus.oDATA   = data_q;
  assign bus.oDVAL   = dval_o_q;
  assign bus.oX_Cont = x_q;
  assign bus.oY_Cont = y_q;
  assign bus.oERR    = err_q;

endmodule

// File: tb/tb_bayer_mosaic_gen.sv
// tb/tb_bayer_mosaic_gen.sv - self-checking bench for bayer_mosaic_gen
module tb_bayer_mosaic_gen;
  localparam int H = 4;
  localparam int V = 2;

  logic iCLK = 1'b0;
  logic iRST = 1'b1;

  bayer_mosaic_gen_if bus ();

  bayer_mosaic_gen #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .bus (bus)
  );

  always #5 iCLK = ~iCLK;

  int n_checks = 0;
  int n_fail   = 0;

  logic [33:0] got_q[$];
  logic [33:0] exp_q[$];

  always @(negedge iCLK) begin
    if (bus.oDVAL === 1'b1) got_q.push_back({bus.oDATA, bus.oX_Cont, bus.oY_Cont});
  end

  // Bayer site rule: even x+y is green, odd column on an even row is red,
  // odd row on an even column is blue.
  function automatic logic [33:0] exp_pix(input logic [11:0] r, g, b, input int x, y);
    logic [11:0] v;
    if ((x + y) % 2 == 0) v = g;
    else if (y % 2 == 0)  v = r;
    else                  v = b;
    return {v, 11'(x), 11'(y)};
  endfunction

  task automatic step(input logic f, d, input logic [11:0] r, g, b);
    @(negedge iCLK);
    bus.iFVAL  = f;
    bus.iDVAL  = d;
    bus.iRed   = r;
    bus.iGreen = g;
    bus.iBlue  = b;
  endtask

  task automatic idle(input logic f);
    step(f, 1'b0, 12'h0, 12'h0, 12'h0);
  endtask

  task automatic drive_line(input int len, input int row, input bit rnd,
                            input logic [11:0] r, g, b);
    logic [11:0] rr, gg, bb;
    for (int k = 0; k < len; k++) begin
      rr = rnd ? 12'($urandom) : r;
      gg = rnd ? 12'($urandom) : g;
      bb = rnd ? 12'($urandom) : b;
      step(1'b1, 1'b1, rr, gg, bb);
      if (row < V && k < H) exp_q.push_back(exp_pix(rr, gg, bb, k, row));
    end
    idle(1'b1);
  endtask

  task automatic test_reset();
    bus.iFVAL = 1'b0; bus.iDVAL = 1'b0;
    bus.iRed = '0; bus.iGreen = '0; bus.iBlue = '0;
    #2 iRST = 1'b0;
    repeat (3) @(negedge iCLK);
    n_checks++;
    if ({bus.oDATA, bus.oDVAL, bus.oX_Cont, bus.oY_Cont, bus.oERR} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h dval=%b x=%0d y=%0d err=%b, expected all 0",
               bus.oDATA, bus.oDVAL, bus.oX_Cont, bus.oY_Cont, bus.oERR);
    end
    iRST = 1'b1;
    idle(1'b0);
  endtask

  task automatic test_phase();
    got_q.delete(); exp_q.delete();
    idle(1'b0);
    drive_line(4, 0, 1'b0, 12'h100, 12'h200, 12'h300);
    drive_line(4, 1, 1'b0, 12'h100, 12'h200, 12'h300);
    idle(1'b0); idle(1'b0);
    n_checks++;
    if (bus.oERR !== 1'b0) begin
      n_fail++; $display("FAIL phase_err: got %b expected 0", bus.oERR);
    end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL phase_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL phase_pix[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if ({bus.oDATA, bus.oX_Cont, bus.oY_Cont} !== exp_q[exp_q.size()-1]) begin
      n_fail++; $display("FAIL phase_hold: got %h expected %h",
                         {bus.oDATA, bus.oX_Cont, bus.oY_Cont}, exp_q[exp_q.size()-1]);
    end
  endtask

  task automatic test_latency();
    logic [11:0] rr, gg, bb;
    logic [33:0] e;
    rr = 12'($urandom); gg = 12'($urandom); bb = 12'($urandom);
    e = exp_pix(rr, gg, bb, 0, 0);
    idle(1'b0);
    idle(1'b1);
    step(1'b1, 1'b1, rr, gg, bb);
    n_checks++;
    if (bus.oDVAL !== 1'b0) begin
      n_fail++; $display("FAIL latency_early: got oDVAL=%b expected 0", bus.oDVAL);
    end
    idle(1'b1);
    n_checks++;
    if ({bus.oDVAL, bus.oDATA, bus.oX_Cont, bus.oY_Cont} !== {1'b1, e}) begin
      n_fail++; $display("FAIL latency_out: got dval=%b %h expected dval=1 %h",
                         bus.oDVAL, {bus.oDATA, bus.oX_Cont, bus.oY_Cont}, e);
    end
    idle(1'b1);
    n_checks++;
    if (bus.oDVAL !== 1'b0) begin
      n_fail++; $display("FAIL latency_width: got oDVAL=%b expected 0", bus.oDVAL);
    end
    idle(1'b0);
  endtask

  task automatic test_overrun();
    logic [11:0] rr, gg, bb;
    got_q.delete(); exp_q.delete();
    idle(1'b0);
    for (int k = 0; k < 6; k++) begin
      rr = 12'($urandom); gg = 12'($urandom); bb = 12'($urandom);
      step(1'b1, 1'b1, rr, gg, bb);
      if (k < H) exp_q.push_back(exp_pix(rr, gg, bb, k, 0));
      if (k == 4) begin
        n_checks++;
        if (bus.oERR !== 1'b0) begin
          n_fail++; $display("FAIL overrun_err_before: got %b expected 0", bus.oERR);
        end
      end
      if (k == 5) begin
        n_checks++;
        if (bus.oERR !== 1'b1) begin
          n_fail++; $display("FAIL overrun_err_after: got %b expected 1", bus.oERR);
        end
      end
    end
    idle(1'b1);
    drive_line(4, 1, 1'b1, 12'h0, 12'h0, 12'h0);
    idle(1'b0); idle(1'b0);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL overrun_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL overrun_pix[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (bus.oERR !== 1'b1) begin
      n_fail++; $display("FAIL overrun_sticky: got %b expected 1", bus.oERR);
    end
  endtask

  task automatic test_short_line();
    logic [11:0] rr, gg, bb;
    logic [33:0] e;
    got_q.delete(); exp_q.delete();
    idle(1'b0);
    drive_line(3, 0, 1'b1, 12'h0, 12'h0, 12'h0);
    n_checks++;
    if (bus.oERR !== 1'b0) begin
      n_fail++; $display("FAIL short_err_before: got %b expected 0", bus.oERR);
    end
    idle(1'b1);
    n_checks++;
    if (bus.oERR !== 1'b1) begin
      n_fail++; $display("FAIL short_err_after: got %b expected 1", bus.oERR);
    end
    idle(1'b1); idle(1'b1);
    n_checks++;
    if (bus.oERR !== 1'b1) begin
      n_fail++; $display("FAIL short_err_sticky: got %b expected 1", bus.oERR);
    end
    idle(1'b0);
    rr = 12'($urandom); gg = 12'($urandom); bb = 12'($urandom);
    e = exp_pix(rr, gg, bb, 0, 0);
    exp_q.push_back(e);
    step(1'b1, 1'b1, rr, gg, bb);
    idle(1'b1);
    n_checks++;
    if ({bus.oERR, bus.oDVAL, bus.oDATA, bus.oX_Cont, bus.oY_Cont} !== {2'b01, e}) begin
      n_fail++; $display("FAIL short_clear: got err=%b dval=%b %h expected err=0 dval=1 %h",
                         bus.oERR, bus.oDVAL, {bus.oDATA, bus.oX_Cont, bus.oY_Cont}, e);
    end
    idle(1'b0); idle(1'b0);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL short_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL short_pix[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_frame_restart();
    logic [11:0] rr, gg, bb;
    logic [33:0] e;
    got_q.delete(); exp_q.delete();
    idle(1'b0);
    drive_line(4, 0, 1'b1, 12'h0, 12'h0, 12'h0);
    for (int k = 0; k < 2; k++) begin
      rr = 12'($urandom); gg = 12'($urandom); bb = 12'($urandom);
      step(1'b1, 1'b1, rr, gg, bb);
      exp_q.push_back(exp_pix(rr, gg, bb, k, 1));
    end
    step(1'b0, 1'b1, 12'($urandom), 12'($urandom), 12'($urandom));
    rr = 12'($urandom); gg = 12'($urandom); bb = 12'($urandom);
    e = exp_pix(rr, gg, bb, 0, 0);
    exp_q.push_back(e);
    step(1'b1, 1'b1, rr, gg, bb);
    idle(1'b1);
    n_checks++;
    if ({bus.oERR, bus.oDVAL, bus.oDATA, bus.oX_Cont, bus.oY_Cont} !== {2'b01, e}) begin
      n_fail++; $display("FAIL restart_out: got err=%b dval=%b %h expected err=0 dval=1 %h",
                         bus.oERR, bus.oDVAL, {bus.oDATA, bus.oX_Cont, bus.oY_Cont}, e);
    end
    idle(1'b0); idle(1'b0);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL restart_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL restart_pix[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [11:0] rr, gg, bb;
    idle(1'b0);
    step(1'b1, 1'b1, 12'h5a5, 12'h3c3, 12'h0f0);
    step(1'b1, 1'b1, 12'h5a5, 12'h3c3, 12'h0f0);
    @(posedge iCLK);
    #3 iRST = 1'b0;
    #1;
    n_checks++;
    if ({bus.oDATA, bus.oDVAL, bus.oX_Cont, bus.oY_Cont, bus.oERR} !== 36'h0) begin
      n_fail++; $display("FAIL async_reset: got data=%h dval=%b x=%0d y=%0d err=%b, expected all 0",
                         bus.oDATA, bus.oDVAL, bus.oX_Cont, bus.oY_Cont, bus.oERR);
    end
    bus.iDVAL = 1'b0;
    @(negedge iCLK); @(negedge iCLK);
    iRST = 1'b1;
    got_q.delete(); exp_q.delete();
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 12'($urandom), 12'($urandom), 12'($urandom));
    idle(1'b1); idle(1'b1);
    n_checks++;
    if (got_q.size() != 0) begin
      n_fail++; $display("FAIL async_ignored: got %0d outputs expected 0", got_q.size());
    end
    n_checks++;
    if (bus.oERR !== 1'b1) begin
      n_fail++; $display("FAIL async_err: got %b expected 1", bus.oERR);
    end
    idle(1'b0);
    rr = 12'($urandom); gg = 12'($urandom); bb = 12'($urandom);
    exp_q.push_back(exp_pix(rr, gg, bb, 0, 0));
    step(1'b1, 1'b1, rr, gg, bb);
    idle(1'b1); idle(1'b0); idle(1'b0);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      n_fail++; $display("FAIL async_resume: got %0d outputs first %h expected 1 output %h",
                         got_q.size(), (got_q.size() > 0) ? got_q[0] : 34'h0, exp_q[0]);
    end
  endtask

  task automatic test_random_frames();
    int nl, len;
    bit e;
    for (int f = 0; f < 25; f++) begin
      got_q.delete(); exp_q.delete();
      nl = $urandom_range(1, V + 1);
      e  = (nl > V);
      repeat ($urandom_range(1, 2)) idle(1'b0);
      for (int r = 0; r < nl; r++) begin
        len = $urandom_range(1, H + 2);
        if (len != H) e = 1'b1;
        drive_line(len, r, 1'b1, 12'h0, 12'h0, 12'h0);
        repeat ($urandom_range(0, 2)) idle(1'b1);
      end
      idle(1'b0); idle(1'b0);
      n_checks++;
      if (bus.oERR !== e) begin
        n_fail++; $display("FAIL rand_err[frame %0d]: got %b expected %b", f, bus.oERR, e);
      end
      n_checks++;
      if (got_q.size() != exp_q.size()) begin
        n_fail++; $display("FAIL rand_count[frame %0d]: got %0d expected %0d",
                           f, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL rand_pix[frame %0d, %0d]: got %h expected %h",
                             f, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_phase();
    test_latency();
    test_overrun();
    test_short_line();
    test_frame_restart();
    test_async_reset();
    test_random_frames();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
